// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter and its receive-side checker.
// Helpers work on a MAX_WIDTH container; callers cast to their own ring width.
package ring_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Rotate toward the MSB within the low 'width' bits; upper bits come back zero.
    function automatic logic [MAX_WIDTH-1:0] rotate_left(input logic [MAX_WIDTH-1:0] value,
                                                         input int width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '1;
        mask = mask >> (MAX_WIDTH - width);
        return ((value << 1) | (value >> (width - 1))) & mask;
    endfunction

    function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] value);
        logic [4:0] count;
        count = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            count = count + 5'(value[i]);
        end
        return (count == 5'd1);
    endfunction

    function automatic logic [3:0] onehot_to_index(input logic [MAX_WIDTH-1:0] value);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (value[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational ring pattern decoder: binary position of the set bit plus a
// one-hot validity flag. Index is meaningless when o_valid is low.
module onehot_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_ring,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid
);

    logic [MAX_WIDTH-1:0] w_ring_wide;

    assign w_ring_wide = MAX_WIDTH'(i_ring);
    assign o_index     = IDX_W'(onehot_to_index(w_ring_wide));
    assign o_valid     = is_onehot(w_ring_wide);

endmodule

// File: rtl/ring_counter_checker.sv
// Receive-side ring checker: decodes each enabled sample, tracks left rotation,
// locks after LOCK_COUNT good steps and counts sequence breaks while locked.
module ring_counter_checker
    import ring_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8,
    localparam int IDX_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDX_W-1:0] index,
    output logic             onehot_ok,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t           r_state;
    logic [3:0]       r_good_cnt;
    logic [WIDTH-1:0] r_prev;
    logic [IDX_W-1:0] r_index;
    logic             r_onehot_ok;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_count;

    logic [IDX_W-1:0] w_index;
    logic             w_valid;
    logic [WIDTH-1:0] w_expected;
    logic             w_prev_onehot;
    logic             w_match;

    onehot_decoder #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_decoder (
        .i_ring (ring_in),
        .o_index(w_index),
        .o_valid(w_valid)
    );

    assign w_expected    = WIDTH'(rotate_left(MAX_WIDTH'(r_prev), WIDTH));
    assign w_prev_onehot = is_onehot(MAX_WIDTH'(r_prev));
    assign w_match       = (ring_in == w_expected);

    // The failing sample is still captured as prev so relock can start from it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_good_cnt  <= '0;
            r_prev      <= '0;
            r_index     <= '0;
            r_onehot_ok <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_seq_err <= 1'b0;
            if (en) begin
                r_onehot_ok <= w_valid;
                r_prev      <= ring_in;
                if (w_valid) begin
                    r_index <= w_index;
                end
                case (r_state)
                    SEARCH: begin
                        if (w_valid && w_prev_onehot && w_match) begin
                            if (r_good_cnt + 4'd1 == LOCK_TARGET) begin
                                r_state    <= LOCKED;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= r_good_cnt + 4'd1;
                            end
                        end else begin
                            r_good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_match) begin
                            r_seq_err  <= 1'b1;
                            r_state    <= SEARCH;
                            r_good_cnt <= '0;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign index     = r_index;
    assign onehot_ok = r_onehot_ok;
    assign locked    = (r_state == LOCKED);
    assign seq_err   = r_seq_err;
    assign err_count = r_err_count;

endmodule

// File: doc/ring_counter_checker.md
Name: ring_counter_checker

Overview:
Receive-side companion to the ring counter. Samples a WIDTH-bit one-hot ring pattern each enabled clock, decodes it to a binary index and confirms one-hot validity. Tracks the expected rotation sequence, locks after consecutive correct steps and flags and counts sequence errors. Sits downstream of a ring counter, or on a board loopback path, as a self-check and observation point.

Parameters:
WIDTH, 4, ring length (bits of ring_in); legal range 2..16
LOCK_COUNT, 2, consecutive correct rotations required to enter LOCKED; range 1..15
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous reset, active-low (asserted when 0)
en  input  1  sample enable; ring_in is evaluated only when en=1
ring_in  input  WIDTH  ring pattern under test
index  output  clog2(WIDTH)  binary position of the set bit of the last valid sample
onehot_ok  output  1  last sample had exactly one bit set
locked  output  1  sequence tracking is locked
seq_err  output  1  single-cycle pulse on a sequence break while locked
err_count  output  ERR_W  number of seq_err pulses, saturating at all-ones

Behaviour:
- Reset (reset=0 at a clk edge) clears everything. index=0, onehot_ok=0, locked=0, seq_err=0, err_count=0, prev=0, good_cnt=0, state=SEARCH.
- Reset overrides en. Reset mid-sequence discards lock and all history.
- All outputs are registered. Results for a sample taken at edge N are visible after edge N, giving 1-cycle latency.
- Rotation direction is left, toward the MSB: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- expected = {prev[WIDTH-2:0], prev[WIDTH-1]}.
- When en=0: all state holds, and seq_err=0 on that cycle.
- When en=1, for each sample:
  - onehot_ok <= (popcount(ring_in)==1).
  - index updates only when the sample is one-hot. Otherwise index holds its old value.
  - prev <= ring_in, always, including invalid samples.
- state SEARCH:
  - Sample one-hot AND prev one-hot AND ring_in==expected: good_cnt++.
  - If the incremented good_cnt reaches LOCK_COUNT: go to LOCKED and clear good_cnt.
  - Any other sample: good_cnt <= 0.
  - seq_err is never asserted in SEARCH.
- state LOCKED:
  - ring_in==expected: stay in LOCKED.
  - Anything else (wrong position, zero, multi-hot, or repeated value): seq_err=1 for one cycle, err_count++ (saturating), go to SEARCH with good_cnt=0.
  - The failing sample becomes prev, so relock can start from it.
- locked = (state==LOCKED), registered.
- Wrap-around: the MSB-set to LSB-set transition counts as a correct step.
- Saturation: at err_count=all-ones, further errors still pulse seq_err but the count holds.
- Back-to-back errors are not possible while locked, because the first error exits LOCKED.
- Width rules: index width is clog2(WIDTH), with a minimum of 1. The popcount uses a WIDTH-sized adder tree, with no truncation.

Decomposition:
- Shared package ring_pkg holds:
  - state enum (SEARCH, LOCKED)
  - the rotate-left function
  - the onehot_to_index function
  - the is_onehot function
- These are shared with the ring counter itself.
- One natural sub-module: onehot_decoder (combinational ring_in -> index plus valid), instantiated once.
- The FSM and counters stay in the top.

Test Plan:
- Reset then run: hold reset=0 for 2 edges, then release. Feed 0001, 0010, 0100 with en=1. Required: outputs stay at reset values during reset. After the 3rd sample, locked=1 and index=2.
- Wrap: while locked, feed 1000 then 0001. Required: index goes 3 then 0, locked stays 1, seq_err=0.
- Sequence break: while locked after 0010, feed 1000. Required: seq_err pulses for exactly 1 cycle, err_count increments 0 -> 1, locked=0. Then 0001, 0010 relocks: locked=1 after the 2nd sample.
- Invalid pattern: while locked, feed 0110. Required: onehot_ok=0, index holds its prior value, seq_err pulse, locked=0. Feed 0000 in SEARCH. Required: no seq_err, good_cnt cleared.
- Enable gating: while locked, set en=0 for 5 cycles with ring_in set to garbage (1111). Required: no output change. Re-enable with the correct next value. Required: locked stays 1.
- Saturation and reset: force 256 lock/break cycles with ERR_W=8. Required: err_count=255 and holds, while seq_err still pulses. Assert reset=0 while locked. Required: all outputs cleared the next cycle.
